// File: rtl/ret_stack_pkg.sv
// ret_stack_pkg: shared processor constants and stack operation decode
package ret_stack_pkg;
    localparam int PC_WIDTH = 32;
    localparam int RS_DEPTH = 16;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_REPLACE,
        OP_PUSH,
        OP_DROP,
        OP_POP,
        OP_UFLOW
    } op_t;

    // Priority: simultaneous push/pop on a non-empty stack rewrites the top,
    // on an empty stack it degrades to a plain push.
    function automatic op_t decode_op(input logic push, input logic pop,
                                      input logic empty, input logic full);
        if (push && pop && !empty) return OP_REPLACE;
        if (push && !full)         return OP_PUSH;
        if (push)                  return OP_DROP;
        if (pop && !empty)         return OP_POP;
        if (pop)                   return OP_UFLOW;
        return OP_IDLE;
    endfunction
endpackage

// File: rtl/ret_stack_if.sv
// ret_stack_if: control-unit push/pop bus plus depth and error reporting
interface ret_stack_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    logic             push;
    logic             pop;
    logic             clr_err;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, clr_err, data_in,
        input  data_out, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, clr_err, data_in,
        output data_out, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/ret_stack_mem.sv
// ret_stack_mem: DEPTH x WIDTH array, one synchronous write port, one asynchronous read port
module ret_stack_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/ret_stack.sv
// ret_stack: hardware return-address stack feeding PC mux input 3
// Stack pointer equals the entry count; valid entries live in mem[0..sp-1].
module ret_stack
    import ret_stack_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH,
    parameter int WIDTH = PC_WIDTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input logic        clk,
    input logic        rst_n,
    ret_stack_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [CNT_W-1:0] sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             empty, full, we;
    logic [AW-1:0]    top, waddr;
    logic [WIDTH-1:0] rdata;
    op_t              op;

    assign empty = sp_q == '0;
    assign full  = sp_q == CNT_W'(DEPTH);
    assign top   = AW'(sp_q - CNT_W'(1));

    // Reset suppresses the memory write as well as the pointer update.
    always_comb begin
        op    = rst_n ? decode_op(bus.push, bus.pop, empty, full) : OP_IDLE;
        we    = op == OP_REPLACE || op == OP_PUSH;
        waddr = op == OP_REPLACE ? top : AW'(sp_q);
        sp_d  = op == OP_PUSH ? sp_q + CNT_W'(1) : op == OP_POP ? sp_q - CNT_W'(1) : sp_q;
        ovf_d = op == OP_DROP  || (ovf_q && !bus.clr_err);
        unf_d = op == OP_UFLOW || (unf_q && !bus.clr_err);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    ret_stack_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (bus.data_in),
        .raddr (top),
        .rdata (rdata)
    );

    assign bus.data_out  = empty ? '0 : rdata;
    assign bus.count     = sp_q;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: tb/tb_ret_stack.sv
// tb_ret_stack: queue-based reference model of the return stack with directed and random stimulus
module tb_ret_stack;
    localparam int DEPTH = 16;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    logic [WIDTH-1:0] q[$];
    bit               m_ovf, m_unf;

    always #5 clk = ~clk;

    ret_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    ret_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit pu, input bit po,
                                input logic [WIDTH-1:0] d, input bit c);
        bit oe, ue;
        oe = 1'b0;
        ue = 1'b0;
        if (!r) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (pu && po && q.size() != 0) q[q.size()-1] = d;
            else if (pu) begin
                if (q.size() < DEPTH) q.push_back(d);
                else oe = 1'b1;
            end else if (po) begin
                if (q.size() != 0) void'(q.pop_back());
                else ue = 1'b1;
            end
            m_ovf = oe || (m_ovf && !c);
            m_unf = ue || (m_unf && !c);
        end
    endtask

    task automatic cyc(input bit r, input bit pu, input bit po,
                       input logic [WIDTH-1:0] d, input bit c);
        rst_n       = r;
        bus.push    = pu;
        bus.pop     = po;
        bus.data_in = d;
        bus.clr_err = c;
        @(posedge clk);
        model_update(r, pu, po, d, c);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_count", 32'(bus.count), 32'(q.size()));
            check("cmp_empty", 32'(bus.empty), 32'(q.size() == 0));
            check("cmp_full", 32'(bus.full), 32'(q.size() == DEPTH));
            check("cmp_overflow", 32'(bus.overflow), 32'(m_ovf));
            check("cmp_underflow", 32'(bus.underflow), 32'(m_unf));
            check("cmp_data_out", bus.data_out, q.size() != 0 ? q[q.size()-1] : 32'h0);
        end
    end

    initial begin
        int bias;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk_en = 1'b1;
        cyc(1, 0, 0, 0, 0);
        check("rst_count", 32'(bus.count), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_data_out", bus.data_out, 0);
        check("rst_flags", {30'h0, bus.overflow, bus.underflow}, 0);

        cyc(1, 1, 0, 32'h10, 0);
        cyc(1, 1, 0, 32'h20, 0);
        cyc(1, 1, 0, 32'h30, 0);
        check("pop1_top", bus.data_out, 32'h30);
        cyc(1, 0, 1, 0, 0);
        check("pop2_top", bus.data_out, 32'h20);
        cyc(1, 0, 1, 0, 0);
        check("pop3_top", bus.data_out, 32'h10);
        cyc(1, 0, 1, 0, 0);
        check("drained_empty", 32'(bus.empty), 1);
        check("drained_data_out", bus.data_out, 0);

        for (int i = 1; i <= DEPTH; i++) cyc(1, 1, 0, 32'(i), 0);
        check("fill_full", 32'(bus.full), 1);
        cyc(1, 1, 0, 32'h99, 0);
        check("ovf_flag", 32'(bus.overflow), 1);
        check("ovf_count", 32'(bus.count), 16);
        check("ovf_data_out", bus.data_out, 16);

        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        check("unf_flag", 32'(bus.underflow), 1);
        check("unf_count", 32'(bus.count), 0);
        cyc(1, 0, 0, 0, 1);
        check("clr_flags", {30'h0, bus.overflow, bus.underflow}, 0);

        cyc(1, 1, 0, 32'h5, 0);
        cyc(1, 1, 1, 32'h7, 0);
        check("replace_count", 32'(bus.count), 1);
        check("replace_data_out", bus.data_out, 32'h7);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 1, 32'h8, 0);
        check("pp_empty_count", 32'(bus.count), 1);
        check("pp_empty_data_out", bus.data_out, 32'h8);
        check("pp_empty_underflow", 32'(bus.underflow), 0);

        cyc(0, 1, 0, 32'h40, 0);
        check("rst_push_count", 32'(bus.count), 0);
        cyc(1, 1, 0, 32'h41, 0);
        check("post_rst_data_out", bus.data_out, 32'h41);

        for (int i = 0; i < 3000; i++) begin
            case ((i / 200) % 3)
                0:       bias = 80;
                1:       bias = 20;
                default: bias = 50;
            endcase
            cyc($urandom_range(199) != 0,
                $urandom_range(99) < bias,
                $urandom_range(99) < (100 - bias),
                $urandom,
                $urandom_range(15) == 0);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
